// File: rtl/mem_bus_arbiter_pkg.sv
// Shared types for the memory bus arbiter: width encoding, FSM states and
// the per-requester pending slot.
package mem_bus_arbiter_pkg;

  typedef enum logic [1:0] {
    MEM_BYTE  = 2'd0,
    MEM_WORD  = 2'd1,
    MEM_DWORD = 2'd2
  } mem_width_e;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_ISSUE,
    ARB_WAIT
  } arb_state_e;

  typedef struct packed {
    logic        valid;
    logic        is_write;
    logic [31:0] addr;
    logic [1:0]  width;
    logic [31:0] data;
  } ArbReq;

endpackage

// File: rtl/memory_bus.sv
// Downstream RAM/MMIO bus: one-cycle dispatch pulse, slave answers with busy
// and read_data.
interface memory_bus;
  logic        dispatch_read;
  logic        dispatch_write;
  logic [31:0] addr;
  logic [1:0]  mem_width;
  logic [31:0] write_data;
  logic        busy;
  logic [31:0] read_data;

  modport master (
    output dispatch_read, dispatch_write, addr, mem_width, write_data,
    input  busy, read_data
  );

  modport slave (
    input  dispatch_read, dispatch_write, addr, mem_width, write_data,
    output busy, read_data
  );
endinterface

// File: rtl/rr_picker.sv
// Combinational round-robin search: first pending index at or after ptr,
// wrapping modulo N_REQ.
module rr_picker #(
  parameter int N_REQ = 3,
  parameter int RR_W  = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] pending,
  input  logic [RR_W-1:0]  ptr,
  output logic [RR_W-1:0]  grant,
  output logic             found
);

  logic [N_REQ-1:0] rot;
  logic [RR_W:0]    sum;

  // rotate so that bit 0 is the requester the pointer names
  assign rot = N_REQ'({pending, pending} >> ptr);

  // lowest set bit of the rotated mask, mapped back to an absolute index
  always_comb begin
    found = 1'b0;
    sum   = '0;
    grant = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (rot[k]) begin
        found = 1'b1;
        sum   = {1'b0, ptr} + (RR_W + 1)'(k);
      end
    end
    if (sum >= (RR_W + 1)'(N_REQ)) sum = sum - (RR_W + 1)'(N_REQ);
    grant = sum[RR_W-1:0];
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares one memory_bus slave between N_REQ requesters. Each requester's
// pulse is latched into its own slot; slots are served one at a time in
// round-robin order, with a watchdog aborting transactions that never finish.
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter int N_REQ          = 3,
  parameter int RR_W           = $clog2(N_REQ),
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                   clk_in,
  input  logic                   rst_in,
  input  logic [N_REQ-1:0]       req_dispatch_read,
  input  logic [N_REQ-1:0]       req_dispatch_write,
  input  logic [N_REQ-1:0][31:0] req_addr,
  input  logic [N_REQ-1:0][1:0]  req_mem_width,
  input  logic [N_REQ-1:0][31:0] req_write_data,
  output logic [N_REQ-1:0]       req_busy,
  output logic [N_REQ-1:0][31:0] req_read_data,
  output logic [N_REQ-1:0]       req_err,
  output logic [RR_W-1:0]        grant_id,
  memory_bus.master              mem_bus
);

  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

  ArbReq [N_REQ-1:0] slot;
  arb_state_e        state;
  logic [RR_W-1:0]   rr_ptr;
  logic [RR_W-1:0]   pick;
  logic [RR_W-1:0]   nxt_ptr;
  logic              pick_ok;
  logic [WD_W-1:0]   wdog;
  logic [N_REQ-1:0]  pending;
  logic              wd_hit;
  logic              done;
  logic              timed_out;

  // pending mask straight from the slot valid bits; busy mirrors it
  always_comb begin
    pending = '0;
    for (int i = 0; i < N_REQ; i++) pending[i] = slot[i].valid;
  end

  assign req_busy = pending;

  rr_picker #(.N_REQ(N_REQ), .RR_W(RR_W)) u_pick (
    .pending (pending),
    .ptr     (rr_ptr),
    .grant   (pick),
    .found   (pick_ok)
  );

  // completion of the granted slot: slave released busy, or watchdog expired
  assign wd_hit    = (wdog == WD_W'(TIMEOUT_CYCLES - 1));
  assign done      = (state == ARB_WAIT) && (!mem_bus.busy || wd_hit);
  assign timed_out = (state == ARB_WAIT) && mem_bus.busy && wd_hit;
  assign nxt_ptr   = (grant_id == RR_W'(N_REQ - 1)) ? '0 : grant_id + 1'b1;

  // arbitration FSM: dispatch, one issue cycle, then wait for the slave
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state                  <= ARB_IDLE;
      grant_id               <= '0;
      rr_ptr                 <= '0;
      wdog                   <= '0;
      mem_bus.dispatch_read  <= 1'b0;
      mem_bus.dispatch_write <= 1'b0;
      mem_bus.addr           <= '0;
      mem_bus.mem_width      <= MEM_DWORD;
      mem_bus.write_data     <= '0;
    end else begin
      case (state)
        ARB_IDLE: begin
          if (pick_ok && !mem_bus.busy) begin
            mem_bus.addr           <= slot[pick].addr;
            mem_bus.mem_width      <= slot[pick].width;
            mem_bus.write_data     <= slot[pick].data;
            mem_bus.dispatch_read  <= !slot[pick].is_write;
            mem_bus.dispatch_write <= slot[pick].is_write;
            grant_id               <= pick;
            state                  <= ARB_ISSUE;
          end
        end
        ARB_ISSUE: begin
          mem_bus.dispatch_read  <= 1'b0;
          mem_bus.dispatch_write <= 1'b0;
          wdog                   <= '0;
          state                  <= ARB_WAIT;
        end
        ARB_WAIT: begin
          if (done) begin
            rr_ptr <= nxt_ptr;
            state  <= ARB_IDLE;
          end else begin
            wdog <= wdog + 1'b1;
          end
        end
        default: state <= ARB_IDLE;
      endcase
    end
  end

  // slot bookkeeping: retire the granted slot first, then accept new pulses
  // so a requester re-pulsing on its completion edge is latched again
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      slot          <= '0;
      req_read_data <= '0;
      req_err       <= '0;
    end else begin
      if (done) begin
        slot[grant_id].valid <= 1'b0;
        if (timed_out)
          req_err[grant_id] <= 1'b1;
        else if (!slot[grant_id].is_write)
          req_read_data[grant_id] <= mem_bus.read_data;
      end
      for (int i = 0; i < N_REQ; i++) begin
        if (req_dispatch_read[i] && req_dispatch_write[i]) begin
          req_err[i] <= 1'b1;
        end else if (req_dispatch_read[i] || req_dispatch_write[i]) begin
          if (slot[i].valid && !(done && grant_id == RR_W'(i))) begin
            req_err[i] <= 1'b1;
          end else begin
            slot[i].valid    <= 1'b1;
            slot[i].is_write <= req_dispatch_write[i];
            slot[i].addr     <= req_addr[i];
            slot[i].width    <= req_mem_width[i];
            slot[i].data     <= req_write_data[i];
          end
        end
      end
    end
  end

endmodule
